// File: rtl/mul4_seq_ctrl.sv
// rtl/mul4_seq_ctrl.sv - sequential 2-limb x 2-limb multiplier controller around a shared limb multiplier
//
// Purpose:
//   Accepts A = {a1,a0} and B = {b1,b0} on an in_valid/in_ready handshake.
//   It then walks the four limb partial products through one external
//   LIMB_W x LIMB_W combinational multiplier (mul_x/mul_y -> mul_p) and adds
//   each product into a 4*LIMB_W accumulator at its limb weight. The product
//   is presented as {y3,y2,y1,y0} on an out_valid/out_ready handshake.
//
// Configuration:
//   MUL4_SEQ_SKIP_ZERO_EN - when defined, a partial-product state whose limb
//   operands include a zero is skipped without spending a cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a1, a0, b1, b0        operand limbs, sampled only on an input transfer
//   in_valid / in_ready   operand handshake (ready only while idle)
//   mul_x, mul_y          operands driven to the shared multiplier
//   mul_p                 combinational product mul_x*mul_y
//   y3, y2, y1, y0        result words, high to low
//   out_valid / out_ready result handshake
//   busy                  high whenever a sequence is in flight or pending
module mul4_seq_ctrl #(
    parameter int LIMB_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LIMB_W-1:0]     a1,
    input  logic [LIMB_W-1:0]     a0,
    input  logic [LIMB_W-1:0]     b1,
    input  logic [LIMB_W-1:0]     b0,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LIMB_W-1:0]     mul_x,
    output logic [LIMB_W-1:0]     mul_y,
    input  logic [2*LIMB_W-1:0]   mul_p,
    output logic [LIMB_W-1:0]     y3,
    output logic [LIMB_W-1:0]     y2,
    output logic [LIMB_W-1:0]     y1,
    output logic [LIMB_W-1:0]     y0,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int ACC_W = 4 * LIMB_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [LIMB_W-1:0]   a1_q, a0_q, b1_q, b0_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    pp_ext, pp_term;
    logic                in_ready_q, busy_q, out_valid_q;
    logic [LIMB_W-1:0]   mul_x_q, mul_y_q;
    logic [LIMB_W-1:0]   y3_q, y2_q, y1_q, y0_q;

    // Bit i set means partial-product state PPi has to run.
    logic [3:0]          live_in, live_q;

    // In IDLE the next operands come straight from the ports (they are being
    // latched on this same edge); otherwise from the latched copies.
    logic [LIMB_W-1:0]   src_a1, src_a0, src_b1, src_b0;

`ifdef MUL4_SEQ_SKIP_ZERO_EN
    assign live_in = {(a1   != '0) && (b1   != '0), (a1   != '0) && (b0   != '0),
                      (a0   != '0) && (b1   != '0), (a0   != '0) && (b0   != '0)};
    assign live_q  = {(a1_q != '0) && (b1_q != '0), (a1_q != '0) && (b0_q != '0),
                      (a0_q != '0) && (b1_q != '0), (a0_q != '0) && (b0_q != '0)};
`else
    assign live_in = 4'b1111;
    assign live_q  = 4'b1111;
`endif

    // First partial-product state still enabled in the mask, else DONE.
    function automatic state_t pick_state(input logic [3:0] live);
        if (live[0])      return S_PP0;
        else if (live[1]) return S_PP1;
        else if (live[2]) return S_PP2;
        else if (live[3]) return S_PP3;
        else              return S_DONE;
    endfunction

    // Multiplier x operand for a state: a0 for PP0/PP1, a1 for PP2/PP3.
    function automatic logic [LIMB_W-1:0] sel_x(input state_t s,
                                                input logic [LIMB_W-1:0] hi,
                                                input logic [LIMB_W-1:0] lo);
        case (s)
            S_PP0, S_PP1: sel_x = lo;
            S_PP2, S_PP3: sel_x = hi;
            default:      sel_x = '0;
        endcase
    endfunction

    // Multiplier y operand for a state: b0 for PP0/PP2, b1 for PP1/PP3.
    function automatic logic [LIMB_W-1:0] sel_y(input state_t s,
                                                input logic [LIMB_W-1:0] hi,
                                                input logic [LIMB_W-1:0] lo);
        case (s)
            S_PP0, S_PP2: sel_y = lo;
            S_PP1, S_PP3: sel_y = hi;
            default:      sel_y = '0;
        endcase
    endfunction

    always_comb begin
        src_a1 = a1_q;
        src_a0 = a0_q;
        src_b1 = b1_q;
        src_b0 = b0_q;
        if (state_q == S_IDLE) begin
            src_a1 = a1;
            src_a0 = a0;
            src_b1 = b1;
            src_b0 = b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = pick_state(live_in);
            S_PP0:   state_d = pick_state(live_q & 4'b1110);
            S_PP1:   state_d = pick_state(live_q & 4'b1100);
            S_PP2:   state_d = pick_state(live_q & 4'b1000);
            S_PP3:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Partial product placed at its limb weight; wraps modulo 2^ACC_W.
    always_comb begin
        pp_ext = {{(2*LIMB_W){1'b0}}, mul_p};
        case (state_q)
            S_PP0:        pp_term = pp_ext;
            S_PP1, S_PP2: pp_term = pp_ext << LIMB_W;
            S_PP3:        pp_term = pp_ext << (2 * LIMB_W);
            default:      pp_term = '0;
        endcase
    end

    assign acc_d = acc_q + pp_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a1_q        <= '0;
            a0_q        <= '0;
            b1_q        <= '0;
            b0_q        <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            y3_q        <= '0;
            y2_q        <= '0;
            y1_q        <= '0;
            y0_q        <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            mul_x_q     <= sel_x(state_d, src_a1, src_a0);
            mul_y_q     <= sel_y(state_d, src_b1, src_b0);

            if (state_q == S_IDLE && in_valid) begin
                a1_q  <= a1;
                a0_q  <= a0;
                b1_q  <= b1;
                b0_q  <= b0;
                acc_q <= '0;
            end else if (state_q == S_PP0 || state_q == S_PP1 ||
                         state_q == S_PP2 || state_q == S_PP3) begin
                acc_q <= acc_d;
            end

            // Results load only on DONE entry. Straight from IDLE means every
            // partial product was skipped, so the product is zero.
            if (state_d == S_DONE && state_q != S_DONE) begin
                if (state_q == S_IDLE) begin
                    {y3_q, y2_q, y1_q, y0_q} <= '0;
                end else begin
                    {y3_q, y2_q, y1_q, y0_q} <= acc_d;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign y3        = y3_q;
    assign y2        = y2_q;
    assign y1        = y1_q;
    assign y0        = y0_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// tb/tb_mul4_seq_ctrl.sv - self-checking bench for mul4_seq_ctrl
module tb_mul4_seq_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   a1 = '0, a0 = '0, b1 = '0, b0 = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   mul_x, mul_y;
    logic [2*W-1:0] mul_p;
    logic [W-1:0]   y3, y2, y1, y0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    mul4_seq_ctrl #(.LIMB_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a1        (a1),
        .a0        (a0),
        .b1        (b1),
        .b0        (b0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .y3        (y3),
        .y2        (y2),
        .y1        (y1),
        .y0        (y0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared external multiplier.
    assign mul_p = 32'(mul_x) * 32'(mul_y);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare process ----------------
    // The model knows only the transaction rules: a transfer happens in IDLE
    // when in_valid is high, the result is A*B, the multiplier sees the
    // enabled limb pairs in order, then the result waits for out_ready.
    logic        m_busy = 1'b0;
    logic        m_done_seen = 1'b0;
    logic [63:0] m_res = '0;
    logic [63:0] m_last = '0;
    logic [31:0] m_q[$];
    logic [31:0] m_pr;
    int          m_cyc = 0;
    int          m_npp = 0;

    function automatic bit pair_runs(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL4_SEQ_SKIP_ZERO_EN
        return (x != 0) && (y != 0);
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_y", {y3, y2, y1, y0}, 64'd0);
            chk("rst_mul", {32'd0, mul_x, mul_y}, 64'd0);
            m_busy = 1'b0;
            m_last = '0;
            m_q.delete();
        end else if (!m_busy) begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_in_ready", 64'(in_ready), 64'd1);
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_mul", {32'd0, mul_x, mul_y}, 64'd0);
            chk("idle_y_kept", {y3, y2, y1, y0}, m_last);
            if (in_valid) begin
                m_busy = 1'b1;
                m_done_seen = 1'b0;
                m_cyc = 0;
                m_res = 64'({a1, a0}) * 64'({b1, b0});
                m_q.delete();
                if (pair_runs(a0, b0)) m_q.push_back({a0, b0});
                if (pair_runs(a0, b1)) m_q.push_back({a0, b1});
                if (pair_runs(a1, b0)) m_q.push_back({a1, b0});
                if (pair_runs(a1, b1)) m_q.push_back({a1, b1});
                m_npp = m_q.size();
            end
        end else begin
            m_cyc++;
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_in_ready", 64'(in_ready), 64'd0);
            if (m_q.size() != 0) begin
                m_pr = m_q.pop_front();
                chk("pp_out_valid", 64'(out_valid), 64'd0);
                chk("pp_mul_x", 64'(mul_x), 64'(m_pr[31:16]));
                chk("pp_mul_y", 64'(mul_y), 64'(m_pr[15:0]));
            end else begin
                chk("done_out_valid", 64'(out_valid), 64'd1);
                chk("done_y", {y3, y2, y1, y0}, m_res);
                chk("done_mul", {32'd0, mul_x, mul_y}, 64'd0);
                if (!m_done_seen) chk("done_latency", 64'(m_cyc), 64'(m_npp + 1));
                m_done_seen = 1'b1;
                if (out_ready) begin
                    m_busy = 1'b0;
                    m_last = m_res;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at #1 after a rising edge. Measures latency counting the
    // transfer edge as edge 1.
    task automatic run_op(input logic [W-1:0] xa1, input logic [W-1:0] xa0,
                          input logic [W-1:0] xb1, input logic [W-1:0] xb0,
                          input logic [63:0] exp_y, input int exp_lat, input string name);
        int lat;
        int guard;
        a1 = xa1; a0 = xa0; b1 = xb1; b0 = xb0;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_y"}, {y3, y2, y1, y0}, exp_y);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held_y;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready_after_release", 64'(in_ready), 64'd1);
        chk("rst_y_after_release", {y3, y2, y1, y0}, 64'd0);

        run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'hFFFF_FFFE_0000_0001, 5, "all_ones");
`ifdef MUL4_SEQ_SKIP_ZERO_EN
        run_op(16'h0001, 16'h0000, 16'h0001, 16'h0000, 64'h0000_0001_0000_0000, 2, "high_limbs");
        run_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h0, 1, "all_zero");
        run_op(16'h0000, 16'h0003, 16'h0000, 16'h0005, 64'd15, 2, "low_limbs");
        run_op(16'h1234, 16'h5678, 16'h0000, 16'h0002, 64'h0000_0000_2468_ACF0, 3, "b1_zero");
`else
        run_op(16'h0001, 16'h0000, 16'h0001, 16'h0000, 64'h0000_0001_0000_0000, 5, "high_limbs");
        run_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h0, 5, "all_zero");
        run_op(16'h0000, 16'h0003, 16'h0000, 16'h0005, 64'd15, 5, "low_limbs");
        run_op(16'h1234, 16'h5678, 16'h0000, 16'h0002, 64'h0000_0000_2468_ACF0, 5, "b1_zero");
`endif

        // Result held while out_ready stays low; new operands are ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op(16'h0002, 16'h0003, 16'h0004, 16'h0005, 64'h0000_0008_0016_000F, 5, "hold_op");
        held_y = {y3, y2, y1, y0};
        for (int i = 0; i < 10; i++) begin
            a1 = W'($urandom); a0 = W'($urandom); b1 = W'($urandom); b0 = W'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_y", {y3, y2, y1, y0}, held_y);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_in_ready", 64'(in_ready), 64'd1);
        chk("hold_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of PP2 throws the sequence away.
        a1 = 16'h00A1; a0 = 16'h00A0; b1 = 16'h00B1; b0 = 16'h00B0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pp2_mul_x", 64'(mul_x), 64'h00A1);
        chk("pp2_mul_y", 64'(mul_y), 64'h00B0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_y", {y3, y2, y1, y0}, 64'd0);
        chk("midrst_mul_x", 64'(mul_x), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'h0000, 16'h0100, 16'h0000, 16'h0100, 64'h0000_0000_0001_0000, 5, "after_rst");

        // Back-to-back random pairs with in_valid held high; zero limbs mixed in.
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a1 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            a0 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            b1 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            b0 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("final_idle_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
